// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory arbitration slice.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 4;
   localparam int DMEM_DATA_W = 8;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } req_t;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_DBG  = 1'b1
   } port_id_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto one single-port dmem: core wins unless debug has starved MAX_WAIT cycles.
// Grant is combinational (ready same cycle); read data returns to the issuing port one cycle later.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_valid,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_ready,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_valid,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic [3:0]        starve_cnt
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

   typedef enum logic {
      NORMAL    = 1'b0,
      FORCE_DBG = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  starve_nxt;
   logic        grant_c, grant_d, force_d;
   req_t        c_req, d_req, sel;
   logic        pend_rd;
   port_id_t    pend_id;
   logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

   assign c_req   = '{we: c_we, addr: c_addr, wdata: c_wdata};
   assign d_req   = '{we: d_we, addr: d_addr, wdata: d_wdata};
   assign force_d = (state == FORCE_DBG);

   always_comb begin
      grant_c    = 1'b0;
      grant_d    = 1'b0;
      sel        = '0;
      starve_nxt = 4'd0;
      state_nxt  = NORMAL;
      // No access may reach the memory while reset is held
      if (reset) begin
         grant_d = d_valid & (~c_valid | force_d);
         grant_c = c_valid & ~grant_d;
      end
      if (grant_d)
         sel = d_req;
      else if (grant_c)
         sel = c_req;
      if (d_valid && !grant_d)
         starve_nxt = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
      if (starve_nxt >= MAX_CNT)
         state_nxt = FORCE_DBG;
   end

   assign c_ready = grant_c;
   assign d_ready = grant_d;
   assign m_en    = grant_c | grant_d;
   assign m_we    = sel.we;
   assign m_addr  = sel.addr;
   assign m_wdata = sel.wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= NORMAL;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_rd   <= 1'b0;
         pend_id   <= PORT_CORE;
         c_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         pend_rd  <= m_en & ~m_we;
         pend_id  <= grant_d ? PORT_DBG : PORT_CORE;
         c_rvalid <= m_en & ~m_we & grant_c;
         d_rvalid <= m_en & ~m_we & grant_d;
         if (pend_rd && pend_id == PORT_CORE)
            c_rdata_q <= m_rdata;
         if (pend_rd && pend_id == PORT_DBG)
            d_rdata_q <= m_rdata;
      end
   end

   // Memory data is live only in the response cycle; the hold registers keep it afterwards
   assign c_rdata = (pend_rd && pend_id == PORT_CORE) ? m_rdata : c_rdata_q;
   assign d_rdata = (pend_rd && pend_id == PORT_DBG)  ? m_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16x8 one-cycle-latency memory model.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_valid, c_we, d_valid, d_we;
   logic [3:0] c_addr, d_addr, m_addr, starve_cnt;
   logic [7:0] c_wdata, d_wdata, c_rdata, d_rdata, m_wdata, m_rdata;
   logic       c_ready, c_rvalid, d_ready, d_rvalid, m_en, m_we;
   logic [7:0] mem [16];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr] <= m_wdata;
         else      m_rdata     <= mem[m_addr];
      end
   end

   dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .starve_cnt(starve_cnt)
   );

   task automatic test_reset();
      reset = 1'b0; c_valid = 1'b1; c_we = 1'b0; c_addr = 4'd1; c_wdata = 8'h00;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 4'd2; d_wdata = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (c_ready !== 1'b0) begin n_bad++; $display("FAIL rst_c_ready got %b want 0", c_ready); end
      n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_ready got %b want 0", d_ready); end
      n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL rst_m_en got %b want 0", m_en); end
      n_cmp++; if (starve_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_starve got %0d want 0", starve_cnt); end
      n_cmp++; if ({c_rvalid, d_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid got %b want 00", {c_rvalid, d_rvalid}); end
      n_cmp++; if ({c_rdata, d_rdata} !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata got %h want 0000", {c_rdata, d_rdata}); end
      @(negedge clk);
      c_valid = 1'b0; d_valid = 1'b0; reset = 1'b1;
   endtask

   task automatic test_core_rw();
      @(negedge clk);
      c_valid = 1'b1; c_we = 1'b1; c_addr = 4'd3; c_wdata = 8'hA5;
      #1;
      n_cmp++; if (c_ready !== 1'b1) begin n_bad++; $display("FAIL rw_wr_ready got %b want 1", c_ready); end
      n_cmp++; if ({m_en, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 4'd3, 8'hA5}) begin n_bad++; $display("FAIL rw_mem_drive got %h want %h", {m_en, m_we, m_addr, m_wdata}, {1'b1, 1'b1, 4'd3, 8'hA5}); end
      @(negedge clk);
      c_we = 1'b0;
      #1;
      n_cmp++; if (c_ready !== 1'b1) begin n_bad++; $display("FAIL rw_rd_ready got %b want 1", c_ready); end
      n_cmp++; if (c_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_wr_no_resp got %b want 0", c_rvalid); end
      @(negedge clk);
      c_valid = 1'b0;
      #1;
      n_cmp++; if (c_rvalid !== 1'b1) begin n_bad++; $display("FAIL rw_rvalid got %b want 1", c_rvalid); end
      n_cmp++; if (c_rdata !== 8'hA5) begin n_bad++; $display("FAIL rw_rdata got %h want a5", c_rdata); end
      n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_d_rvalid got %b want 0", d_rvalid); end
      n_cmp++; if ({m_en, m_we, m_addr, m_wdata} !== 14'h0) begin n_bad++; $display("FAIL rw_idle_mem got %h want 0", {m_en, m_we, m_addr, m_wdata}); end
      @(negedge clk);
      #1;
      n_cmp++; if (c_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_rvalid_pulse got %b want 0", c_rvalid); end
      n_cmp++; if (c_rdata !== 8'hA5) begin n_bad++; $display("FAIL rw_rdata_hold got %h want a5", c_rdata); end
   endtask

   task automatic test_dbg_fill();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         d_valid = 1'b1; d_we = 1'b1; d_addr = 4'(i); d_wdata = 8'(i * 8'h11);
         #1;
         n_cmp++; if ({d_ready, c_ready} !== 2'b10) begin n_bad++; $display("FAIL fill_ready[%0d] got d=%b c=%b want d=1 c=0", i, d_ready, c_ready); end
      end
      @(negedge clk);
      d_we = 1'b0; d_addr = 4'd15;
      #1;
      n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL fill_rd_ready got %b want 1", d_ready); end
      @(negedge clk);
      d_valid = 1'b0;
      #1;
      n_cmp++; if (d_rvalid !== 1'b1) begin n_bad++; $display("FAIL fill_d_rvalid got %b want 1", d_rvalid); end
      n_cmp++; if (d_rdata !== 8'hFF) begin n_bad++; $display("FAIL fill_d_rdata got %h want ff", d_rdata); end
      n_cmp++; if ({c_rvalid, c_rdata} !== {1'b0, 8'hA5}) begin n_bad++; $display("FAIL fill_core_side got %b/%h want 0/a5", c_rvalid, c_rdata); end
   endtask

   task automatic test_alternate();
      @(negedge clk);
      c_valid = 1'b1; c_we = 1'b0; c_addr = 4'd2;
      #1;
      n_cmp++; if (c_ready !== 1'b1) begin n_bad++; $display("FAIL alt_c_ready got %b want 1", c_ready); end
      @(negedge clk);
      c_valid = 1'b0; d_valid = 1'b1; d_we = 1'b0; d_addr = 4'd5;
      #1;
      n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL alt_d_ready got %b want 1", d_ready); end
      n_cmp++; if ({c_rvalid, c_rdata} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL alt_core_resp got %b/%h want 1/22", c_rvalid, c_rdata); end
      n_cmp++; if ({d_rvalid, d_rdata} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL alt_dbg_quiet got %b/%h want 0/ff", d_rvalid, d_rdata); end
      @(negedge clk);
      d_valid = 1'b0;
      #1;
      n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 8'h55}) begin n_bad++; $display("FAIL alt_dbg_resp got %b/%h want 1/55", d_rvalid, d_rdata); end
      n_cmp++; if ({c_rvalid, c_rdata} !== {1'b0, 8'h22}) begin n_bad++; $display("FAIL alt_core_hold got %b/%h want 0/22", c_rvalid, c_rdata); end
   endtask

   task automatic test_starvation();
      logic [3:0] exp_s;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         c_valid = 1'b1; c_we = 1'b0; c_addr = 4'(k);
         d_valid = 1'b1; d_we = 1'b0; d_addr = 4'(15 - k);
         exp_s = 4'(k % 5);
         #1;
         n_cmp++; if (starve_cnt !== exp_s) begin n_bad++; $display("FAIL starve_cnt[%0d] got %0d want %0d", k, starve_cnt, exp_s); end
         n_cmp++; if ({c_ready, d_ready} !== ((k % 5 == 4) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL starve_grant[%0d] got c=%b d=%b", k, c_ready, d_ready); end
      end
      @(negedge clk);
      c_valid = 1'b0; d_valid = 1'b0;
      #1;
      n_cmp++; if (starve_cnt !== 4'd0) begin n_bad++; $display("FAIL starve_end got %0d want 0", starve_cnt); end
   endtask

   task automatic test_dbg_drop();
      logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         c_valid = 1'b1; c_we = 1'b0; c_addr = 4'd0;
         d_valid = (k < 2); d_we = 1'b1; d_addr = 4'd7; d_wdata = 8'h00;
         #1;
         n_cmp++; if (starve_cnt !== exp_s[k]) begin n_bad++; $display("FAIL drop_cnt[%0d] got %0d want %0d", k, starve_cnt, exp_s[k]); end
         n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL drop_d_ready[%0d] got %b want 0", k, d_ready); end
      end
      @(negedge clk);
      c_valid = 1'b0; d_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      c_valid = 1'b1; c_we = 1'b0; c_addr = 4'd4;
      #1;
      n_cmp++; if (c_ready !== 1'b1) begin n_bad++; $display("FAIL mid_c_ready got %b want 1", c_ready); end
      @(negedge clk);
      c_valid = 1'b0; reset = 1'b0;
      #1;
      n_cmp++; if ({c_rvalid, c_rdata} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL mid_flush got %b/%h want 0/00", c_rvalid, c_rdata); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if ({c_rvalid, starve_cnt} !== 5'd0) begin n_bad++; $display("FAIL mid_release got rv=%b cnt=%0d want 0/0", c_rvalid, starve_cnt); end
      @(negedge clk);
      #1;
      n_cmp++; if ({c_rvalid, d_rvalid} !== 2'b00) begin n_bad++; $display("FAIL mid_no_pulse got %b want 00", {c_rvalid, d_rvalid}); end
   endtask

   initial begin
      test_reset();
      test_core_rw();
      test_dbg_fill();
      test_alternate();
      test_starvation();
      test_dbg_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
